memory_page_reader: RTL and testbench

Read-side sequencer for the paged BRAM Memory block. The memory holds 8 pages of 128 entries, and each page has a 7-bit entry count (nent).
On a start request for one page, this block issues nent consecutive reads (addrb/enb), tracks the fixed BRAM read latency and buffers returned words in a small skid FIFO. It then presents them to the downstream processing stage over a valid/ready stream with a last flag.
Memory read clock clkb is tied to clka at integration.

---
 rtl/memory_page_reader.sv | 197 +++++++++++++++++++
 tb/tb_memory_page_reader.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_page_reader.sv
// memory_page_reader: read-side sequencer for the paged BRAM.
// On start it latches a page and its entry count, then issues that many
// consecutive reads. Issue is credit-limited so returned words always fit in
// the skid FIFO. Returned words are delivered on a valid/ready stream that
// carries a last flag.
//
// Ports:
//   clka, rstb         clock; synchronous active-high reset
//   start, page        one-cycle page read request (ignored while busy)
//   nent_all           per-page entry counts, page p at [p*ENT_BITS +: ENT_BITS]
//   busy, done         busy from accepted start; done pulses when page delivered
//   addrb, enb, regceb memory read port ({page, index}, enable, out-reg enable)
//   mem_dout           memory read data, valid LAT cycles after enb
//   dout, dout_valid,
//   dout_ready,
//   dout_last          output stream (FIFO head), last marks final entry
module memory_page_reader #(
    parameter int RAM_WIDTH  = 18,
    parameter int PAGE_BITS  = 3,
    parameter int ENT_BITS   = 7,
    parameter int LAT        = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                              clka,
    input  logic                              rstb,
    input  logic                              start,
    input  logic [PAGE_BITS-1:0]              page,
    input  logic [(2**PAGE_BITS)*ENT_BITS-1:0] nent_all,
    output logic                              busy,
    output logic                              done,
    output logic [PAGE_BITS+ENT_BITS-1:0]     addrb,
    output logic                              enb,
    output logic                              regceb,
    input  logic [RAM_WIDTH-1:0]              mem_dout,
    output logic [RAM_WIDTH-1:0]              dout,
    output logic                              dout_valid,
    input  logic                              dout_ready,
    output logic                              dout_last
);

    localparam int NPAGES = 2 ** PAGE_BITS;
    localparam int PW     = $clog2(FIFO_DEPTH);
    localparam int CW     = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

    state_e                state_q, state_d;
    logic [PAGE_BITS-1:0]  pg_q, pg_d;
    logic [ENT_BITS-1:0]   n_q, n_d;
    logic [ENT_BITS-1:0]   idx_q, idx_d;
    logic [LAT-1:0]        vld_pipe_q, vld_pipe_d;
    logic [LAT-1:0]        last_pipe_q, last_pipe_d;
    logic [FIFO_DEPTH-1:0] fifo_last_q, fifo_last_d;
    logic [PW-1:0]         wptr_q, wptr_d;
    logic [PW-1:0]         rptr_q, rptr_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  done_q, done_d;
    logic [RAM_WIDTH-1:0]  fifo_data_q [FIFO_DEPTH];

    logic [ENT_BITS-1:0]   nent_sel;
    logic [CW:0]           used;
    logic                  credit_ok;
    logic                  issue;
    logic                  is_last_issue;
    logic                  push;
    logic                  pop;
    logic                  head_last;

    always_comb begin
        nent_sel = '0;
        for (int p = 0; p < NPAGES; p++) begin
            if (page == PAGE_BITS'(p)) nent_sel = nent_all[p*ENT_BITS +: ENT_BITS];
        end
    end

    // Reads in flight plus words already buffered must stay below the FIFO
    // depth, so every returning word is guaranteed a slot.
    always_comb begin
        used = {1'b0, cnt_q};
        for (int i = 0; i < LAT; i++) begin
            used = used + {{CW{1'b0}}, vld_pipe_q[i]};
        end
        credit_ok = used < (CW+1)'(FIFO_DEPTH);
    end

    assign issue         = (state_q == StIssue) && credit_ok;
    assign is_last_issue = (idx_q == n_q - ENT_BITS'(1));
    assign push          = vld_pipe_q[LAT-1];
    assign dout_valid    = (cnt_q != '0);
    assign pop           = dout_valid && dout_ready;
    assign head_last     = fifo_last_q[rptr_q];

    assign enb        = issue;
    assign addrb      = issue ? {pg_q, idx_q} : '0;
    assign regceb     = 1'b1;
    assign busy       = (state_q != StIdle);
    assign done       = done_q;
    assign dout       = fifo_data_q[rptr_q];
    assign dout_last  = dout_valid && head_last;

    always_comb begin
        state_d = state_q;
        pg_d    = pg_q;
        n_d     = n_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    pg_d  = page;
                    n_d   = nent_sel;
                    idx_d = '0;
                    if (nent_sel == '0) begin
                        // Empty page: nothing to read, finish next cycle.
                        state_d = StDrain;
                        done_d  = 1'b1;
                    end else begin
                        state_d = StIssue;
                    end
                end
            end
            StIssue: begin
                if (issue) begin
                    idx_d = idx_q + ENT_BITS'(1);
                    if (is_last_issue) state_d = StDrain;
                end
            end
            StDrain: begin
                if (n_q == '0) begin
                    state_d = StIdle;
                end else if (pop && head_last) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Latency pipeline: one (valid, last) tag per issued read.
    always_comb begin
        vld_pipe_d     = vld_pipe_q;
        last_pipe_d    = last_pipe_q;
        vld_pipe_d[0]  = issue;
        last_pipe_d[0] = issue && is_last_issue;
        for (int i = 1; i < LAT; i++) begin
            vld_pipe_d[i]  = vld_pipe_q[i-1];
            last_pipe_d[i] = last_pipe_q[i-1];
        end
    end

    always_comb begin
        wptr_d      = push ? wptr_q + PW'(1) : wptr_q;
        rptr_d      = pop ? rptr_q + PW'(1) : rptr_q;
        fifo_last_d = fifo_last_q;
        if (push) fifo_last_d[wptr_q] = last_pipe_q[LAT-1];
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clka) begin
        if (rstb) begin
            state_q     <= StIdle;
            pg_q        <= '0;
            n_q         <= '0;
            idx_q       <= '0;
            vld_pipe_q  <= '0;
            last_pipe_q <= '0;
            fifo_last_q <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            cnt_q       <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pg_q        <= pg_d;
            n_q         <= n_d;
            idx_q       <= idx_d;
            vld_pipe_q  <= vld_pipe_d;
            last_pipe_q <= last_pipe_d;
            fifo_last_q <= fifo_last_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
        end
    end

    // Data storage needs no reset; occupancy is tracked by cnt_q.
    always_ff @(posedge clka) begin
        if (push) fifo_data_q[wptr_q] <= mem_dout;
    end

endmodule

// File: tb/tb_memory_page_reader.sv
// Bench for memory_page_reader: directed page scenarios plus a randomized
// soak, all checked every cycle against a transaction-level model.
module tb_memory_page_reader;

    localparam int RW  = 18;
    localparam int PB  = 3;
    localparam int EB  = 7;
    localparam int LAT = 2;
    localparam int FD  = 4;

    logic              clka = 1'b0;
    logic              rstb = 1'b1;
    logic              start = 1'b0;
    logic [PB-1:0]     page = '0;
    logic [8*EB-1:0]   nent_all = '0;
    logic              busy, done, enb, regceb, dout_valid, dout_last;
    logic [PB+EB-1:0]  addrb;
    logic [RW-1:0]     mem_dout, dout;
    logic              dout_ready = 1'b1;

    always #5 clka = ~clka;

    memory_page_reader #(
        .RAM_WIDTH(RW), .PAGE_BITS(PB), .ENT_BITS(EB), .LAT(LAT), .FIFO_DEPTH(FD)
    ) dut (
        .clka(clka), .rstb(rstb), .start(start), .page(page), .nent_all(nent_all),
        .busy(busy), .done(done), .addrb(addrb), .enb(enb), .regceb(regceb),
        .mem_dout(mem_dout), .dout(dout), .dout_valid(dout_valid),
        .dout_ready(dout_ready), .dout_last(dout_last)
    );

    // Memory: content of address a is a; LAT-cycle read, garbage otherwise.
    logic [RW-1:0] mp [LAT];
    always @(posedge clka) begin
        mp[0] <= enb ? RW'(addrb) : RW'($urandom);
        for (int i = 1; i < LAT; i++) mp[i] <= mp[i-1];
    end
    assign mem_dout = mp[LAT-1];

    int cyc = 0;
    always @(posedge clka) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic int nent_of(input int p);
        logic [8*EB-1:0] t;
        t = nent_all >> (p * EB);
        return int'(t[EB-1:0]);
    endfunction

    // Reference model: page-level view of pending reads and returning beats.
    bit          armed = 1'b0;
    bit          m_busy = 1'b0, m_done = 1'b0, m_zero = 1'b0;
    int          to_issue = 0, idx_m = 0, n_m = 0, base_m = 0;
    logic [RW:0] beats [$];
    int          arr [$];

    // Per-page observation log for the literal checks.
    int t_start, lg_nenb, lg_first_enb, lg_first_addr, lg_last_addr, lg_first_valid;
    int lg_nbeats, lg_nlast, lg_last_rel, lg_done_rel, lg_busy;

    function automatic void clear_log();
        lg_nenb = 0; lg_first_enb = -1; lg_first_addr = -1; lg_last_addr = -1;
        lg_first_valid = -1; lg_nbeats = 0; lg_nlast = 0; lg_last_rel = -1;
        lg_done_rel = -1; lg_busy = 0;
    endfunction

    always @(negedge clka) begin
        logic        exp_valid, exp_enb, pop, lst;
        logic [RW:0] hd;
        bit          nb, nd, nz;
        hd        = (beats.size() > 0) ? beats[0] : '0;
        exp_valid = (beats.size() > 0) && (arr[0] <= cyc);
        exp_enb   = (to_issue > 0) && (beats.size() < FD);
        if (armed) begin
            check("busy", busy, m_busy);
            check("done", done, m_done);
            check("enb", enb, exp_enb);
            if (exp_enb) check("addrb", addrb, base_m + idx_m);
            check("dout_valid", dout_valid, exp_valid);
            check("dout_last", dout_last, exp_valid && hd[RW]);
            if (exp_valid) check("dout", dout, hd[RW-1:0]);
            if (!rstb) begin
                lg_busy += int'(busy);
                if (enb) begin
                    if (lg_nenb == 0) begin
                        lg_first_addr = int'(addrb);
                        lg_first_enb  = cyc - t_start;
                    end
                    lg_last_addr = int'(addrb);
                    lg_nenb++;
                end
                if (dout_valid && lg_first_valid < 0) lg_first_valid = cyc - t_start;
                if (dout_valid && dout_ready) begin
                    lg_nbeats++;
                    if (dout_last) begin
                        lg_nlast++;
                        lg_last_rel = cyc - t_start;
                    end
                end
                if (done) lg_done_rel = cyc - t_start;
            end
        end
        if (rstb) begin
            armed = 1'b1; m_busy = 1'b0; m_done = 1'b0; m_zero = 1'b0;
            to_issue = 0; beats.delete(); arr.delete(); clear_log();
        end else if (armed) begin
            pop = exp_valid && dout_ready;
            nb = m_busy; nd = 1'b0; nz = 1'b0;
            if (m_zero) nb = 1'b0;
            if (pop) begin
                if (hd[RW]) begin
                    nb = 1'b0;
                    nd = 1'b1;
                end
                void'(beats.pop_front());
                void'(arr.pop_front());
            end
            if (exp_enb) begin
                lst = (idx_m == n_m - 1);
                beats.push_back({lst, RW'(base_m + idx_m)});
                arr.push_back(cyc + LAT + 1);
                idx_m++;
                to_issue--;
            end
            if (start && !m_busy) begin
                n_m = nent_of(int'(page)); base_m = int'(page) * 128;
                idx_m = 0; to_issue = n_m; nb = 1'b1;
                if (n_m == 0) begin
                    nd = 1'b1;
                    nz = 1'b1;
                end
                clear_log();
                t_start = cyc;
            end
            m_busy = nb; m_done = nd; m_zero = nz;
        end
    end

    // Ready pattern: 0 = high, 1 = toggle, 2 = random, 3 = low.
    int mode = 0;
    initial forever begin
        @(posedge clka);
        #2;
        case (mode)
            0:       dout_ready = 1'b1;
            1:       dout_ready = ~dout_ready;
            2:       dout_ready = 1'($urandom % 2);
            default: dout_ready = 1'b0;
        endcase
    end

    task automatic tick();
        @(posedge clka);
        #1;
    endtask

    task automatic set_nent(input int p, input int v);
        logic [8*EB-1:0] m, d;
        m = {{(7*EB){1'b0}}, {EB{1'b1}}} << (p * EB);
        d = (8*EB)'(v) << (p * EB);
        nent_all = (nent_all & ~m) | (d & m);
    endtask

    task automatic do_start(input int p);
        page = PB'(p);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic finish_page();
        int k;
        k = 0;
        while (m_busy && k < 3000) begin
            tick();
            k++;
        end
        check("wait_idle_bound", k < 3000, 1);
        tick();
        tick();
    endtask

    function automatic int pick_nent();
        int r;
        r = $urandom % 8;
        if (r == 0) return 0;
        if (r == 1) return 127;
        return $urandom_range(1, 12);
    endfunction

    initial begin
        int k;
        rstb = 1'b1;
        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_enb", enb, 0);
        check("rst_addrb", addrb, 0);
        check("rst_valid", dout_valid, 0);
        check("rst_last", dout_last, 0);
        check("regceb", regceb, 1);
        rstb = 1'b0;
        tick();

        // 1: page 2, five entries, ready high.
        set_nent(2, 5);
        do_start(2);
        finish_page();
        check("t1_first_enb", lg_first_enb, 1);
        check("t1_nenb", lg_nenb, 5);
        check("t1_first_addr", lg_first_addr, 256);
        check("t1_last_addr", lg_last_addr, 260);
        check("t1_first_valid", lg_first_valid, 4);
        check("t1_nbeats", lg_nbeats, 5);
        check("t1_nlast", lg_nlast, 1);
        check("t1_last_rel", lg_last_rel, 8);
        check("t1_done_rel", lg_done_rel, 9);

        // 2: empty page.
        set_nent(0, 0);
        do_start(0);
        finish_page();
        check("t2_done_rel", lg_done_rel, 1);
        check("t2_busy_cycles", lg_busy, 1);
        check("t2_nenb", lg_nenb, 0);
        check("t2_first_valid", lg_first_valid, -1);

        // 3: full page, ready toggling.
        mode = 1;
        set_nent(7, 127);
        do_start(7);
        finish_page();
        check("t3_nbeats", lg_nbeats, 127);
        check("t3_nenb", lg_nenb, 127);
        check("t3_first_addr", lg_first_addr, 896);
        check("t3_last_addr", lg_last_addr, 1022);
        check("t3_nlast", lg_nlast, 1);

        // 4: ready held low for 10 cycles.
        mode = 3;
        tick();
        set_nent(1, 6);
        do_start(1);
        repeat (9) tick();
        check("t4_stalled_nenb", lg_nenb, 4);
        mode = 0;
        finish_page();
        check("t4_nenb", lg_nenb, 6);
        check("t4_nbeats", lg_nbeats, 6);
        check("t4_last_addr", lg_last_addr, 133);

        // 5: start while busy ignored; start in done cycle accepted.
        set_nent(3, 4);
        set_nent(5, 3);
        do_start(3);
        tick();
        do_start(5);
        k = 0;
        while (done !== 1'b1 && k < 100) begin
            tick();
            k++;
        end
        check("t5_done_bound", k < 100, 1);
        check("t5_nenb", lg_nenb, 4);
        check("t5_first_addr", lg_first_addr, 384);
        check("t5_last_addr", lg_last_addr, 387);
        do_start(5);
        finish_page();
        check("t5b_first_addr", lg_first_addr, 640);
        check("t5b_nbeats", lg_nbeats, 3);

        // 6: reset mid-page, then rerun the page.
        set_nent(4, 10);
        do_start(4);
        tick();
        tick();
        rstb = 1'b1;
        tick();
        rstb = 1'b0;
        check("t6_busy", busy, 0);
        check("t6_valid", dout_valid, 0);
        check("t6_enb", enb, 0);
        repeat (5) tick();
        do_start(4);
        finish_page();
        check("t6_nbeats", lg_nbeats, 10);
        check("t6_first_addr", lg_first_addr, 512);
        check("t6_nlast", lg_nlast, 1);

        // Randomized soak.
        mode = 2;
        for (int p = 0; p < 8; p++) set_nent(p, pick_nent());
        repeat (4000) begin
            start = ($urandom % 6 == 0);
            page  = PB'($urandom);
            if ($urandom % 20 == 0) begin
                for (int p = 0; p < 8; p++) set_nent(p, pick_nent());
            end
            rstb = ($urandom % 400 == 0);
            tick();
        end
        start = 1'b0;
        rstb = 1'b0;
        mode = 0;
        finish_page();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
